// File: rtl/uart_frame_rx.sv
// Frame assembler behind the UART receiver: SOF, LEN, payload, CHK.
// The buffered payload is replayed over a valid/ready stream.
module uart_frame_rx #(
   parameter int             DW      = 8,
   parameter int             MAX_LEN = 16,
   parameter logic [DW-1:0]  SOF     = 8'hFE,
   parameter int             TIMEOUT = 8680
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rx_rcv,
   input  logic [DW-1:0]                rx_data,
   input  logic                         rx_par_err,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DW-1:0]                out_data,
   output logic                         out_last,
   output logic [$clog2(MAX_LEN+1)-1:0] out_len,
   output logic                         busy,
   output logic                         err_chk,
   output logic                         err_par,
   output logic                         err_len,
   output logic                         err_tmo,
   output logic                         err_ovr
);

   localparam int LW = $clog2(MAX_LEN+1);
   localparam int IW = $clog2(MAX_LEN);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_OUT
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] wr_idx_q, wr_idx_d;
   logic [LW-1:0] rd_idx_q, rd_idx_d;
   logic [DW-1:0] sum_q, sum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          mem_we;
   logic          e_chk, e_par, e_len, e_tmo, e_ovr;
   logic [DW-1:0] mem [MAX_LEN];

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      sum_d    = sum_q;
      tmo_d    = '0;
      mem_we   = 1'b0;
      e_chk    = 1'b0;
      e_par    = 1'b0;
      e_len    = 1'b0;
      e_tmo    = 1'b0;
      e_ovr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_rcv && !rx_par_err && rx_data == SOF)
               state_d = S_LEN;
         end
         S_LEN: begin
            if (rx_rcv) begin
               if (rx_par_err) begin
                  e_par   = 1'b1;
                  state_d = S_IDLE;
               end else if (rx_data == '0 || rx_data > DW'(MAX_LEN)) begin
                  e_len   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  len_d    = LW'(rx_data);
                  sum_d    = rx_data;
                  wr_idx_d = '0;
                  state_d  = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_rcv) begin
               if (rx_par_err) begin
                  e_par   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  mem_we   = 1'b1;
                  sum_d    = sum_q + rx_data;
                  wr_idx_d = wr_idx_q + 1'b1;
                  if (wr_idx_q == len_q - 1'b1)
                     state_d = S_CHK;
               end
            end
         end
         S_CHK: begin
            if (rx_rcv) begin
               if (rx_par_err) begin
                  e_par   = 1'b1;
                  state_d = S_IDLE;
               end else if (rx_data == sum_q) begin
                  rd_idx_d = '0;
                  state_d  = S_OUT;
               end else begin
                  e_chk   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_OUT: begin
            e_ovr = rx_rcv;
            if (out_ready) begin
               if (rd_idx_q == len_q - 1'b1)
                  state_d = S_IDLE;
               else
                  rd_idx_d = rd_idx_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // an arriving byte always beats an expiring idle counter
      if (state_q inside {S_LEN, S_PAYLOAD, S_CHK} && !rx_rcv) begin
         if (tmo_q == TW'(TIMEOUT-1)) begin
            e_tmo   = 1'b1;
            state_d = S_IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         sum_q     <= '0;
         tmo_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_len   <= '0;
         busy      <= 1'b0;
         err_chk   <= 1'b0;
         err_par   <= 1'b0;
         err_len   <= 1'b0;
         err_tmo   <= 1'b0;
         err_ovr   <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         sum_q     <= sum_d;
         tmo_q     <= tmo_d;
         out_valid <= (state_d == S_OUT);
         out_data  <= (state_d == S_OUT) ? mem[rd_idx_d[IW-1:0]] : '0;
         out_last  <= (state_d == S_OUT) && (rd_idx_d == len_q - 1'b1);
         out_len   <= (state_d == S_OUT) ? len_q : '0;
         busy      <= (state_d != S_IDLE);
         err_chk   <= e_chk;
         err_par   <= e_par;
         err_len   <= e_len;
         err_tmo   <= e_tmo;
         err_ovr   <= e_ovr;
      end
   end

   // payload buffer needs no reset; it is only read after a full frame
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_idx_q[IW-1:0]] <= rx_data;
   end

endmodule
